// File: rtl/frogger_round_if.sv
// Bundle between the frog/collision logic, the HUD digit renderer and the
// round controller.
//   start_game, pause, frog_dead, frog_home : game events into the controller
//   tens_digit, ones_digit                  : BCD remaining seconds of the life
//   lives_left, wins_count                  : match counters
//   frog_reset, playing, game_over, victory : decoded round status
//   timeout_flag                            : last life ended by timer expiry
// master = game side (drives events), slave = round controller.
interface frogger_round_if;
    logic       start_game;
    logic       pause;
    logic       frog_dead;
    logic       frog_home;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic [2:0] lives_left;
    logic [2:0] wins_count;
    logic       frog_reset;
    logic       playing;
    logic       game_over;
    logic       victory;
    logic       timeout_flag;

    modport master (
        output start_game, pause, frog_dead, frog_home,
        input  tens_digit, ones_digit, lives_left, wins_count,
        input  frog_reset, playing, game_over, victory, timeout_flag
    );

    modport slave (
        input  start_game, pause, frog_dead, frog_home,
        output tens_digit, ones_digit, lives_left, wins_count,
        output frog_reset, playing, game_over, victory, timeout_flag
    );
endinterface

// File: rtl/frogger_round_ctrl.sv
// Round/match controller for Frogger. Counts down a per-life timer on the
// frame clock, handles deaths (including timeout), home arrivals, pause,
// respawn and the terminal GAME_OVER / VICTORY states.
//   frame_clk    : frame clock, all state changes on its rising edge
//   game_restart : asynchronous active-high reset of the whole match
//   bus          : frogger_round_if slave (events in, HUD/status out)
module frogger_round_ctrl #(
    parameter int FRAME_HZ       = 60,
    parameter int TIME_LIMIT     = 60,
    parameter int LIVES          = 3,
    parameter int WINS_TO_FINISH = 3
) (
    input  logic            frame_clk,
    input  logic            game_restart,
    frogger_round_if.slave  bus
);

    localparam int              FC_W    = $clog2(FRAME_HZ);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_HZ - 1);
    localparam logic [6:0]      T_INIT  = 7'(TIME_LIMIT);
    localparam logic [2:0]      L_INIT  = 3'(LIVES);
    localparam logic [3:0]      W_GOAL  = 4'(WINS_TO_FINISH);

    typedef enum logic [2:0] {
        S_RESPAWN,
        S_PLAY,
        S_DEAD,
        S_WIN,
        S_GAME_OVER,
        S_VICTORY
    } state_t;

    state_t          state, state_nxt;
    logic [FC_W-1:0] frame_cnt;
    logic [6:0]      timer;
    logic [2:0]      lives_left;
    logic [2:0]      wins_count;
    logic            timeout_flag;
    logic            frame_run;
    logic            sec_tick;

    // Frames only advance in PLAY when no event and no pause is present,
    // so an event landing on a tick frame swallows that tick.
    assign frame_run = (state == S_PLAY) && !bus.frog_dead && !bus.frog_home && !bus.pause;
    assign sec_tick  = frame_run && (frame_cnt == FC_LAST);

    always_ff @(posedge frame_clk or posedge game_restart) begin
        if (game_restart) begin
            state <= S_RESPAWN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESPAWN: state_nxt = S_PLAY;
            S_PLAY: begin
                if (bus.frog_dead) begin
                    state_nxt = S_DEAD;
                end else if (bus.frog_home) begin
                    state_nxt = S_WIN;
                end else if (sec_tick && timer <= 7'd1) begin
                    state_nxt = S_DEAD;
                end
            end
            S_DEAD: state_nxt = (lives_left <= 3'd1) ? S_GAME_OVER : S_RESPAWN;
            S_WIN: begin
                if ({1'b0, wins_count} + 4'd1 >= W_GOAL) begin
                    state_nxt = S_VICTORY;
                end else begin
                    state_nxt = S_RESPAWN;
                end
            end
            S_GAME_OVER, S_VICTORY: begin
                if (bus.start_game) begin
                    state_nxt = S_RESPAWN;
                end
            end
            default: state_nxt = S_RESPAWN;
        endcase
    end

    always_ff @(posedge frame_clk or posedge game_restart) begin
        if (game_restart) begin
            timer        <= T_INIT;
            frame_cnt    <= '0;
            lives_left   <= L_INIT;
            wins_count   <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_RESPAWN: begin
                    timer        <= T_INIT;
                    frame_cnt    <= '0;
                    timeout_flag <= 1'b0;
                end
                S_PLAY: begin
                    if (sec_tick) begin
                        frame_cnt <= '0;
                        if (timer != 7'd0) begin
                            timer <= timer - 7'd1;
                        end
                        if (timer <= 7'd1) begin
                            timeout_flag <= 1'b1;
                        end
                    end else if (frame_run) begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end
                S_DEAD: begin
                    if (lives_left != 3'd0) begin
                        lives_left <= lives_left - 3'd1;
                    end
                end
                S_WIN: begin
                    if (wins_count != 3'd7) begin
                        wins_count <= wins_count + 3'd1;
                    end
                end
                S_GAME_OVER, S_VICTORY: begin
                    if (bus.start_game) begin
                        lives_left <= L_INIT;
                        wins_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tens_digit   = 4'(timer / 7'd10);
    assign bus.ones_digit   = 4'(timer % 7'd10);
    assign bus.lives_left   = lives_left;
    assign bus.wins_count   = wins_count;
    assign bus.timeout_flag = timeout_flag;
    assign bus.frog_reset   = (state == S_RESPAWN);
    assign bus.playing      = (state == S_PLAY);
    assign bus.game_over    = (state == S_GAME_OVER);
    assign bus.victory      = (state == S_VICTORY);

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Bench for frogger_round_ctrl: per-cycle expected HUD/status snapshots from
// a behavioural match model are queued by the driver and compared by an
// independent monitor.
module tb_frogger_round_ctrl;

    localparam int FHZ = 4;
    localparam int TL  = 12;
    localparam int NL  = 3;
    localparam int NW  = 3;

    localparam int PH_RESPAWN = 0;
    localparam int PH_PLAY    = 1;
    localparam int PH_DEAD    = 2;
    localparam int PH_WIN     = 3;
    localparam int PH_OVER    = 4;
    localparam int PH_VICT    = 5;

    logic frame_clk    = 1'b0;
    logic game_restart = 1'b1;

    frogger_round_if bus ();

    frogger_round_ctrl #(
        .FRAME_HZ      (FHZ),
        .TIME_LIMIT    (TL),
        .LIVES         (NL),
        .WINS_TO_FINISH(NW)
    ) dut (
        .frame_clk   (frame_clk),
        .game_restart(game_restart),
        .bus         (bus)
    );

    always #5 frame_clk = ~frame_clk;

    // Match model: seconds left, frames into the current second, counters.
    int m_phase, m_secs, m_frames, m_lives, m_wins;
    bit m_tflag;

    logic [18:0] exp_q[$];
    int n_check = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit pause_lvl = 1'b0;

    task automatic model_reset();
        m_phase  = PH_RESPAWN;
        m_secs   = TL;
        m_frames = 0;
        m_lives  = NL;
        m_wins   = 0;
        m_tflag  = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit d, input bit h);
        case (m_phase)
            PH_RESPAWN: begin
                m_secs   = TL;
                m_frames = 0;
                m_tflag  = 1'b0;
                m_phase  = PH_PLAY;
            end
            PH_PLAY: begin
                if (d) m_phase = PH_DEAD;
                else if (h) m_phase = PH_WIN;
                else if (!p) begin
                    m_frames++;
                    if (m_frames == FHZ) begin
                        m_frames = 0;
                        m_secs--;
                        if (m_secs == 0) begin
                            m_tflag = 1'b1;
                            m_phase = PH_DEAD;
                        end
                    end
                end
            end
            PH_DEAD: begin
                m_lives--;
                m_phase = (m_lives == 0) ? PH_OVER : PH_RESPAWN;
            end
            PH_WIN: begin
                m_wins++;
                m_phase = (m_wins == NW) ? PH_VICT : PH_RESPAWN;
            end
            default: begin
                if (s) begin
                    m_lives = NL;
                    m_wins  = 0;
                    m_phase = PH_RESPAWN;
                end
            end
        endcase
    endtask

    function automatic logic [18:0] model_out();
        return {4'(m_secs / 10), 4'(m_secs % 10), 3'(m_lives), 3'(m_wins),
                m_phase == PH_RESPAWN, m_phase == PH_PLAY, m_phase == PH_OVER,
                m_phase == PH_VICT, m_tflag};
    endfunction

    task automatic drive(input bit r, input bit s, input bit p, input bit d, input bit h);
        @(negedge frame_clk);
        game_restart   = r;
        bus.start_game = s;
        bus.pause      = p;
        bus.frog_dead  = d;
        bus.frog_home  = h;
        if (r) model_reset();
        else model_step(s, p, d, h);
        exp_q.push_back(model_out());
    endtask

    task automatic budget_fail(input string what);
        n_check++;
        n_fail++;
        $display("FAIL %s: cycle budget expired, target phase not reached (model phase %0d)", what, m_phase);
    endtask

    // Monitor: one snapshot comparison per clock edge that has an expectation.
    initial begin
        logic [18:0] exp, act;
        forever begin
            @(posedge frame_clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {bus.tens_digit, bus.ones_digit, bus.lives_left, bus.wins_count,
                       bus.frog_reset, bus.playing, bus.game_over, bus.victory, bus.timeout_flag};
                n_check++;
                if (act === exp) begin
                    n_pass++;
                end else begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL outputs @%0t: got digits=%0d%0d lives=%0d wins=%0d rst/play/over/vic/tmo=%b, want digits=%0d%0d lives=%0d wins=%0d rst/play/over/vic/tmo=%b",
                                 $time, act[18:15], act[14:11], act[10:8], act[7:5], act[4:0],
                                 exp[18:15], exp[14:11], exp[10:8], exp[7:5], exp[4:0]);
                end
            end
        end
    end

    initial begin
        int budget;
        bus.start_game = 1'b0;
        bus.pause      = 1'b0;
        bus.frog_dead  = 1'b0;
        bus.frog_home  = 1'b0;

        // Reset state, then an idle life that runs out of time.
        drive(1, 0, 0, 0, 0);
        repeat (TL * FHZ + 8) drive(0, 0, 0, 0, 0);

        // Pause mid-second; start_game is offered while waiting and must be ignored.
        budget = 0;
        while (!(m_phase == PH_PLAY && m_frames == 2) && budget < 200) begin
            drive(0, 1, 0, 0, 0);
            budget++;
        end
        if (budget >= 200) budget_fail("pause_setup");
        repeat (10) drive(0, 0, 1, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0);

        // Death and home in the same cycle.
        budget = 0;
        while (m_phase != PH_PLAY && budget < 50) begin drive(0, 0, 0, 0, 0); budget++; end
        if (budget >= 50) budget_fail("dual_event_setup");
        drive(0, 0, 0, 1, 1);
        repeat (3) drive(0, 0, 0, 0, 0);

        // Die until GAME_OVER, poke it with ignored events, then restart.
        budget = 0;
        while (m_phase != PH_OVER && budget < 300) begin
            drive(0, 0, 0, m_phase == PH_PLAY, 0);
            budget++;
        end
        if (budget >= 300) budget_fail("game_over");
        repeat (6) drive(0, 0, 1'($urandom_range(0, 1)), 1, 1);
        drive(0, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);

        // Reach home until VICTORY, a few idle frames between arrivals.
        budget = 0;
        while (m_phase != PH_VICT && budget < 300) begin
            drive(0, 0, 0, 0, m_phase == PH_PLAY && m_frames == 1);
            budget++;
        end
        if (budget >= 300) budget_fail("victory");
        repeat (5) drive(0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 0);

        // Random soak.
        repeat (2500) begin
            if ($urandom_range(0, 15) == 0) pause_lvl = ~pause_lvl;
            drive($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0, pause_lvl,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
        end

        // Reset during the DEAD cycle of the last life.
        budget = 0;
        while (!(m_phase == PH_DEAD && m_lives == 1) && budget < 600) begin
            drive(0, m_phase == PH_OVER || m_phase == PH_VICT, 0, m_phase == PH_PLAY, 0);
            budget++;
        end
        if (budget >= 600) budget_fail("reset_in_dead");
        drive(1, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge frame_clk);
        #3;
        if (exp_q.size() > 0) budget_fail("drain");
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/frogger_round_ctrl.md
Name: frogger_round_ctrl

Overview:
Parametrised round/match controller for the Frogger game. It replaces the fixed 60 s / 3-win game clock with configurable time limit, frame rate, lives and wins-to-finish. It adds per-life respawn, a timeout-as-death rule, pause, and terminal GAME_OVER/VICTORY states. It sits between the frog/collision logic (which reports death and home-arrival pulses) and the HUD digit renderer, and runs on the frame clock.

Parameters:
FRAME_HZ, 60, frame_clk edges per game second (>=2)
TIME_LIMIT, 60, seconds per life (1..99)
LIVES, 3, lives per match (1..7)
WINS_TO_FINISH, 3, home arrivals needed for victory (1..7)

Ports:
frame_clk  in  1  frame clock; all state updates on rising edge
game_restart  in  1  asynchronous active-high reset
start_game  in  1  one-cycle pulse; starts a new match from GAME_OVER or VICTORY
pause  in  1  level; freezes the timer in PLAY
frog_dead  in  1  one-cycle pulse; frog hit or drowned
frog_home  in  1  one-cycle pulse; frog reached a home slot
tens_digit  out  4  BCD tens of remaining seconds
ones_digit  out  4  BCD ones of remaining seconds
lives_left  out  3  lives remaining
wins_count  out  3  home arrivals this match
frog_reset  out  1  high during RESPAWN; frog logic returns frog to start
playing  out  1  high in PLAY
game_over  out  1  high in GAME_OVER
victory  out  1  high in VICTORY
timeout_flag  out  1  last life was lost to timer expiry; cleared on RESPAWN

Behaviour:
- Reset (async, any state): state=RESPAWN, timer=TIME_LIMIT, frame_cnt=0, lives_left=LIVES, wins_count=0, timeout_flag=0. Outputs: frog_reset=1, playing=0, game_over=0, victory=0, digits=BCD(TIME_LIMIT).
- All status outputs are Moore, decoded from state. Digits are combinational from timer: tens=timer/10, ones=timer%10.
- States: RESPAWN, PLAY, DEAD, WIN, GAME_OVER, VICTORY.
- RESPAWN, 1 cycle: timer<=TIME_LIMIT, frame_cnt<=0, timeout_flag<=0. Next state is PLAY.
- PLAY, evaluated each edge in priority order:
  (1) frog_dead -> DEAD.
  (2) else frog_home -> WIN.
  (3) else if pause: hold frame_cnt and timer.
  (4) else if frame_cnt==FRAME_HZ-1: frame_cnt<=0 and timer<=timer-1. If timer was 1, timer becomes 0, timeout_flag<=1 and next state is DEAD.
  (5) else frame_cnt<=frame_cnt+1.
  An event in the same cycle as a tick suppresses that tick. The timer never underflows.
- DEAD, 1 cycle: lives_left<=lives_left-1. If lives_left was 1 -> GAME_OVER, else -> RESPAWN. The timer value is held through DEAD.
- WIN, 1 cycle: wins_count<=wins_count+1. If wins_count+1==WINS_TO_FINISH -> VICTORY, else -> RESPAWN. lives_left is unchanged.
- GAME_OVER / VICTORY:
  - Hold all counters; the digits keep their final value.
  - frog_dead, frog_home and pause are ignored.
  - start_game reloads lives_left=LIVES and wins_count=0, then goes to RESPAWN.
  - start_game is ignored in all other states.
- Latencies:
  - Event pulse to DEAD/WIN: 1 edge.
  - Event pulse to frog_reset high: 2 edges.
  - From frog_reset high to playing high: 1 edge.
- Widths:
  - frame_cnt is $clog2(FRAME_HZ) bits.
  - timer is 7 bits.
  - All decrements are guarded, so no wrap-around is possible.
- Reset mid-operation (any state, including DEAD/WIN): the match is fully reinitialised; no partial counter update is retained.

Test Plan:
1. Reset, then idle with FRAME_HZ=4, TIME_LIMIT=3 -> frog_reset for 1 cycle. Digits go 0,3 -> 0,2 after 4 PLAY cycles -> 0,1 -> 0,0, then DEAD, timeout_flag=1, lives_left 3->2, RESPAWN, digits 0,3.
2. Defaults; frog_dead pulses in 3 separate PLAY windows -> lives 3->2->1->0. game_over=1 and stays after further frog_dead/frog_home. start_game -> lives 3, wins 0, RESPAWN.
3. Defaults; 3 frog_home pulses -> wins 1,2,3; victory=1 on the third. lives_left stays 3. Timer reloads to 60 (digits 6,0) after each of the first two.
4. frog_dead and frog_home in the same cycle -> DEAD taken. wins_count unchanged, lives_left decrements.
5. FRAME_HZ=4; pause held 10 cycles mid-second -> timer and frame_cnt frozen. Release -> tick occurs after the remaining frames only.
6. Assert game_restart during the DEAD cycle with lives_left=1 -> state RESPAWN, lives 3, wins 0, game_over never asserted.
